// File: rtl/spi_rx_auditor.sv
// SPI slave receiver with per-line glitch filters, frame-length audit, MISO response
// shifter, ready/valid output and saturating error/overflow counters.
module spi_rx_auditor #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CPOL     = 0,
    parameter int unsigned CPHA     = 0,
    parameter int unsigned THRESH   = 30,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_ok,
    output logic              over_thresh,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [1:0]        led
);

    localparam int unsigned       BC_W     = $clog2(DATA_W + 2);
    localparam logic              SCK_IDLE = (CPOL != 0);
    localparam logic [DATA_W-1:0] THRESH_W = DATA_W'(THRESH);
    localparam logic [BC_W-1:0]   BC_FULL  = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]   BC_SAT   = BC_W'(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StEval} state_e;

    state_e state_q, state_d;

    logic [FILT_LEN-1:0] cs_hist_q, sck_hist_q, mosi_hist_q;
    logic                cs_f_q, sck_f_q, mosi_f_q;
    logic                cs_p_q, sck_p_q;

    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_ok_q, frame_ok_d;
    logic              over_q, over_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;

    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    // Line filters: a filtered value only moves once its whole history agrees.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cs_hist_q   <= '1;
            sck_hist_q  <= {FILT_LEN{SCK_IDLE}};
            mosi_hist_q <= '0;
            cs_f_q      <= 1'b1;
            sck_f_q     <= SCK_IDLE;
            mosi_f_q    <= 1'b0;
            cs_p_q      <= 1'b1;
            sck_p_q     <= SCK_IDLE;
        end else begin
            cs_hist_q   <= {cs_hist_q[FILT_LEN-2:0], spi_cs};
            sck_hist_q  <= {sck_hist_q[FILT_LEN-2:0], spi_sck};
            mosi_hist_q <= {mosi_hist_q[FILT_LEN-2:0], spi_mosi};
            if (&cs_hist_q) cs_f_q <= 1'b1;
            else if (~|cs_hist_q) cs_f_q <= 1'b0;
            if (&sck_hist_q) sck_f_q <= 1'b1;
            else if (~|sck_hist_q) sck_f_q <= 1'b0;
            if (&mosi_hist_q) mosi_f_q <= 1'b1;
            else if (~|mosi_hist_q) mosi_f_q <= 1'b0;
            cs_p_q  <= cs_f_q;
            sck_p_q <= sck_f_q;
        end
    end

    assign cs_fall     = ~cs_f_q & cs_p_q;
    assign cs_rise     = cs_f_q & ~cs_p_q;
    assign sck_rise    = sck_f_q & ~sck_p_q;
    assign sck_fall    = ~sck_f_q & sck_p_q;
    assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
    assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        first_d    = first_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        frame_ok_d = frame_ok_q;
        over_d     = over_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        // Consumption; a load in EVAL below overrides it in the same cycle.
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StShift;
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    first_d    = 1'b1;
                end
            end
            StShift: begin
                // CS rise wins over a coincident sample edge.
                if (cs_rise) begin
                    state_d = StEval;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_f_q};
                        if (bit_cnt_q != BC_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // With CPHA=1 the MSB is already on MISO at the first leading edge.
                    if (shift_edge && !((CPHA != 0) && first_q)) tx_shift_d = tx_shift_q << 1;
                    if (lead_edge) first_d = 1'b0;
                end
            end
            StEval: begin
                state_d    = StIdle;
                frame_ok_d = (bit_cnt_q == BC_FULL);
                if (bit_cnt_q == BC_FULL) begin
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        over_d     = (rx_shift_q > THRESH_W);
                    end else if (ovf_q != '1) begin
                        ovf_d = ovf_q + 1'b1;
                    end
                end else if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            first_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            frame_ok_q <= 1'b1;
            over_q     <= 1'b0;
            err_q      <= '0;
            ovf_q      <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            first_q    <= first_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            frame_ok_q <= frame_ok_d;
            over_q     <= over_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign spi_miso    = (state_q == StShift) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_ok    = frame_ok_q;
    assign over_thresh = over_q;
    assign err_count   = err_q;
    assign ovf_count   = ovf_q;
    assign led         = {~frame_ok_q, ~over_q};

endmodule

// File: tb/tb_spi_rx_auditor.sv
// Bench for spi_rx_auditor: one DUT per SPI mode, a bit-banged master and a
// frame-level reference model (good/bad length, accept/drop, saturating counts).
module tb_spi_rx_auditor;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int TH = 30;
    localparam int CW = 8;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    cs;
    logic          sck, mosi;
    logic [DW-1:0] tx_data;
    logic          rx_ready;

    logic          miso     [4];
    logic [DW-1:0] rx_data  [4];
    logic          rx_valid [4];
    logic          frame_ok [4];
    logic          over     [4];
    logic [CW-1:0] errc     [4];
    logic [CW-1:0] ovfc     [4];
    logic [1:0]    led      [4];

    logic [DW-1:0] m_data  [4];
    bit            m_valid [4];
    bit            m_ok    [4];
    bit            m_over  [4];
    int            m_err   [4];
    int            m_ovf   [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    genvar m;
    generate
        for (m = 0; m < 4; m++) begin : g_dut
            spi_rx_auditor #(
                .DATA_W(DW), .FILT_LEN(FL), .CPOL(m / 2), .CPHA(m % 2), .THRESH(TH), .CNT_W(CW)
            ) u_dut (
                .clk_in(clk), .rst(rst), .spi_cs(cs[m]), .spi_sck(sck), .spi_mosi(mosi),
                .spi_miso(miso[m]), .tx_data(tx_data), .rx_data(rx_data[m]),
                .rx_valid(rx_valid[m]), .rx_ready(rx_ready), .frame_ok(frame_ok[m]),
                .over_thresh(over[m]), .err_count(errc[m]), .ovf_count(ovfc[m]), .led(led[m])
            );
        end
    endgenerate

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0; m_valid[i] = 0; m_ok[i] = 1; m_over[i] = 0; m_err[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    // Master: drives one frame of nbits (MSB first) and collects MISO; updates the model.
    task automatic send_frame(input logic [1:0] idx, input logic [15:0] data, input int nbits,
                              input bit glitch, input bit eval_pulse, output logic [15:0] mw);
        logic cpol, cpha;
        int   gl;
        bit   rdy;
        cpol = idx[1];
        cpha = idx[0];
        mw   = '0;
        sck  = cpol;
        cycles(H);
        cs[idx] = 1'b0;
        cycles(2 * H);
        for (int i = nbits - 1; i >= 0; i--) begin
            gl = (i % (FL - 1)) + 1;
            if (!cpha) begin
                mosi = data[4'(i)];
                if (glitch) begin
                    cycles(4); cs[idx] = 1'b1; cycles(gl); cs[idx] = 1'b0; cycles(H - 4 - gl);
                end else cycles(H);
                mw  = {mw[14:0], miso[idx]};
                sck = ~cpol;
                if (glitch) begin
                    cycles(4); sck = cpol; cycles(gl); sck = ~cpol; cycles(H - 4 - gl);
                end else cycles(H);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = data[4'(i)];
                cycles(H);
                mw  = {mw[14:0], miso[idx]};
                sck = cpol;
                cycles(H);
            end
        end
        cycles(H);
        cs[idx] = 1'b1;
        if (eval_pulse) begin
            // rx_ready high only during the evaluation cycle.
            cycles(FL + 2); rx_ready = 1'b1; cycles(1); rx_ready = 1'b0; cycles(H);
        end else begin
            cycles(FL + H);
        end
        rdy = eval_pulse ? 1'b1 : rx_ready;
        if (nbits == DW) begin
            m_ok[idx] = 1;
            if (!m_valid[idx] || rdy) begin
                m_data[idx]  = data[DW-1:0];
                m_valid[idx] = 1;
                m_over[idx]  = (data[DW-1:0] > TH);
            end else if (m_ovf[idx] < 255) m_ovf[idx]++;
        end else begin
            m_ok[idx] = 0;
            if (m_err[idx] < 255) m_err[idx]++;
        end
        if (rx_ready && !eval_pulse) m_valid[idx] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 4'($urandom); sck = 1'($urandom); mosi = 1'($urandom);
        tx_data = 8'($urandom); rx_ready = 1'($urandom);
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] k;
            k = 2'(i);
            checks++; if (rx_valid[k] !== 1'b0) begin errors++;
                $display("FAIL reset_rx_valid[%0d]: got %b want 0", i, rx_valid[k]); end
            checks++; if (led[k] !== 2'b01) begin errors++;
                $display("FAIL reset_led[%0d]: got %b want 01", i, led[k]); end
            checks++; if (errc[k] !== 8'd0 || ovfc[k] !== 8'd0) begin errors++;
                $display("FAIL reset_counts[%0d]: got %0d/%0d want 0/0", i, errc[k], ovfc[k]); end
            checks++; if (miso[k] !== 1'b0) begin errors++;
                $display("FAIL reset_miso[%0d]: got %b want 0", i, miso[k]); end
            checks++; if (rx_data[k] !== 8'h00) begin errors++;
                $display("FAIL reset_rx_data[%0d]: got %h want 00", i, rx_data[k]); end
        end
        cs = 4'hF; sck = 1'b0; mosi = 1'b0;
        cycles(2);
        rst = 1'b0;
        model_reset();
        cycles(H);
    endtask

    task automatic test_mode0();
        logic [7:0]  vals [3];
        logic [7:0]  tx;
        logic [15:0] mw;
        vals = '{8'h2A, 8'h1E, 8'h1F};
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx = 8'($urandom);
            tx_data = tx;
            send_frame(2'd0, {8'h00, vals[i]}, DW, 1'b0, 1'b0, mw);
            checks++; if (rx_data[0] !== m_data[0]) begin errors++;
                $display("FAIL mode0_rx_data: got %h want %h", rx_data[0], m_data[0]); end
            checks++; if (over[0] !== m_over[0] || led[0][0] !== !m_over[0]) begin errors++;
                $display("FAIL mode0_over: got %b led %b want %b", over[0], led[0], m_over[0]); end
            checks++; if (rx_valid[0] !== m_valid[0] || frame_ok[0] !== m_ok[0]) begin errors++;
                $display("FAIL mode0_valid_ok: got %b%b want %b%b", rx_valid[0], frame_ok[0],
                         m_valid[0], m_ok[0]); end
            checks++; if (mw[7:0] !== tx) begin errors++;
                $display("FAIL mode0_miso: got %h want %h", mw[7:0], tx); end
        end
    endtask

    task automatic test_modes();
        logic [15:0] mw;
        rx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            logic [1:0] k;
            k = 2'(i);
            tx_data = 8'h3C;
            send_frame(k, 16'h00A5, DW, 1'b0, 1'b0, mw);
            checks++; if (rx_data[k] !== m_data[k]) begin errors++;
                $display("FAIL mode%0d_rx_data: got %h want %h", i, rx_data[k], m_data[k]); end
            checks++; if (mw[7:0] !== 8'h3C) begin errors++;
                $display("FAIL mode%0d_miso: got %h want 3c", i, mw[7:0]); end
            checks++; if (errc[k] !== 8'(m_err[k]) || frame_ok[k] !== m_ok[k]) begin errors++;
                $display("FAIL mode%0d_err: got %0d ok %b want %0d ok %b", i, errc[k],
                         frame_ok[k], m_err[k], m_ok[k]); end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] mw;
        rx_ready = 1'b1;
        tx_data = 8'($urandom);
        send_frame(2'd0, 16'h0055, DW, 1'b1, 1'b0, mw);
        checks++; if (rx_data[0] !== m_data[0]) begin errors++;
            $display("FAIL glitch_rx_data: got %h want %h", rx_data[0], m_data[0]); end
        checks++; if (errc[0] !== 8'(m_err[0]) || frame_ok[0] !== 1'b1) begin errors++;
            $display("FAIL glitch_err: got %0d ok %b want %0d ok 1", errc[0], frame_ok[0],
                     m_err[0]); end
    endtask

    task automatic test_bad_frames();
        logic [15:0] mw;
        int          lens [2];
        lens = '{7, 9};
        for (int i = 0; i < 2; i++) begin
            send_frame(2'd0, 16'($urandom), lens[i], 1'b0, 1'b0, mw);
            checks++; if (frame_ok[0] !== m_ok[0] || led[0][1] !== !m_ok[0]) begin errors++;
                $display("FAIL bad%0d_ok: got %b led %b want ok %b", lens[i], frame_ok[0],
                         led[0], m_ok[0]); end
            checks++; if (errc[0] !== 8'(m_err[0])) begin errors++;
                $display("FAIL bad%0d_err: got %0d want %0d", lens[i], errc[0], m_err[0]); end
            checks++; if (rx_data[0] !== m_data[0]) begin errors++;
                $display("FAIL bad%0d_rx_data: got %h want %h", lens[i], rx_data[0], m_data[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] mw;
        rx_ready = 1'b0;
        send_frame(2'd0, 16'h0010, DW, 1'b0, 1'b0, mw);
        send_frame(2'd0, 16'h0020, DW, 1'b0, 1'b0, mw);
        checks++; if (rx_data[0] !== m_data[0] || rx_valid[0] !== m_valid[0]) begin errors++;
            $display("FAIL bp_hold: got %h v%b want %h v%b", rx_data[0], rx_valid[0],
                     m_data[0], m_valid[0]); end
        checks++; if (ovfc[0] !== 8'(m_ovf[0])) begin errors++;
            $display("FAIL bp_ovf: got %0d want %0d", ovfc[0], m_ovf[0]); end
        send_frame(2'd0, 16'h0033, DW, 1'b0, 1'b1, mw);
        checks++; if (rx_data[0] !== m_data[0] || rx_valid[0] !== m_valid[0]) begin errors++;
            $display("FAIL bp_same_cycle: got %h v%b want %h v%b", rx_data[0], rx_valid[0],
                     m_data[0], m_valid[0]); end
        checks++; if (ovfc[0] !== 8'(m_ovf[0])) begin errors++;
            $display("FAIL bp_same_cycle_ovf: got %0d want %0d", ovfc[0], m_ovf[0]); end
        rx_ready = 1'b1;
        cycles(2);
        m_valid[0] = 0;
        checks++; if (rx_valid[0] !== m_valid[0]) begin errors++;
            $display("FAIL bp_consume: got %b want %b", rx_valid[0], m_valid[0]); end
    endtask

    task automatic test_reset_mid_frame();
        tx_data = 8'($urandom);
        sck = 1'b0;
        cs[0] = 1'b0;
        cycles(2 * H);
        mosi = 1'b1; sck = 1'b1; cycles(H); sck = 1'b0; cycles(H); sck = 1'b1; cycles(4);
        rst = 1'b1; cs = 4'hF; sck = 1'b0;
        cycles(3);
        rst = 1'b0;
        model_reset();
        cycles(4 * H);
        checks++; if (errc[0] !== 8'(m_err[0]) || ovfc[0] !== 8'(m_ovf[0])) begin errors++;
            $display("FAIL midrst_counts: got %0d/%0d want %0d/%0d", errc[0], ovfc[0],
                     m_err[0], m_ovf[0]); end
        checks++; if (rx_valid[0] !== m_valid[0] || rx_data[0] !== m_data[0]) begin errors++;
            $display("FAIL midrst_rx: got %h v%b want %h v%b", rx_data[0], rx_valid[0],
                     m_data[0], m_valid[0]); end
        checks++; if (frame_ok[0] !== m_ok[0] || miso[0] !== 1'b0) begin errors++;
            $display("FAIL midrst_ok_miso: got %b %b want %b 0", frame_ok[0], miso[0],
                     m_ok[0]); end
    endtask

    task automatic test_random();
        logic [15:0] mw;
        int          nb;
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 4))
                0:       nb = 7;
                4:       nb = 9;
                default: nb = 8;
            endcase
            rx_ready = 1'($urandom);
            tx_data  = 8'($urandom);
            send_frame(2'd0, 16'($urandom), nb, 1'b0, 1'b0, mw);
            checks++; if (rx_data[0] !== m_data[0] || rx_valid[0] !== m_valid[0]) begin errors++;
                $display("FAIL rand%0d_rx: got %h v%b want %h v%b", f, rx_data[0], rx_valid[0],
                         m_data[0], m_valid[0]); end
            checks++; if (errc[0] !== 8'(m_err[0]) || ovfc[0] !== 8'(m_ovf[0])) begin errors++;
                $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", f, errc[0], ovfc[0],
                         m_err[0], m_ovf[0]); end
            checks++; if (frame_ok[0] !== m_ok[0] || over[0] !== m_over[0]) begin errors++;
                $display("FAIL rand%0d_flags: got ok%b ov%b want ok%b ov%b", f, frame_ok[0],
                         over[0], m_ok[0], m_over[0]); end
        end
    endtask

    initial begin
        rst = 1'b1; cs = 4'hF; sck = 1'b0; mosi = 1'b0; tx_data = '0; rx_ready = 1'b0;
        model_reset();
        test_reset();
        test_mode0();
        test_modes();
        test_glitch();
        test_bad_frames();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
